fm_sb_ctrl_trig: RTL

Parametrised spy-buffer control block for the FM (fast monitoring) subsystem. Fans software control out to SB_N spy buffers as per-channel freeze, playback-mode, init and reset signals. Supersedes fixed 32-bit-register masking: channel count and widths are generic, and it adds a trigger-armed freeze FSM with programmable post-trigger delay, a trigger counter, and stretched per-channel reset pulses.

---
 rtl/fm_sb_ctrl_trig.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/fm_sb_ctrl_trig.sv
// fm_sb_ctrl_trig: spy-buffer control fan-out for the FM subsystem.
// Generates per-channel freeze, playback mode, memory-init and stretched
// reset signals, plus a trigger-armed freeze FSM with post-trigger delay
// and a saturating trigger counter.
// Optional build macro FM_SB_CTRL_AUTO_REARM_EN: FROZEN self-releases after
// FROZEN_HOLD cycles and returns to ARMED (arm still high) for periodic
// snapshots; without it FROZEN holds until arm falls or init occurs.
module fm_sb_ctrl_trig #(
  parameter int unsigned SB_N             = 128,
  parameter int unsigned PB_MODE_W        = 2,
  parameter int unsigned DELAY_W          = 16,
  parameter int unsigned RST_PULSE_CYCLES = 4,
  parameter int unsigned FROZEN_HOLD      = 1024
) (
  input  logic                      axi_clk,
  input  logic                      axi_reset,
  input  logic                      global_freeze_i,
  input  logic                      arm_i,
  input  logic                      trig_i,
  input  logic [DELAY_W-1:0]        post_trig_dly_i,
  input  logic [SB_N-1:0]           freeze_mask_i,
  input  logic [PB_MODE_W-1:0]      pb_mode_i,
  input  logic [SB_N-1:0]           playback_mask_i,
  input  logic                      init_spy_mem_i,
  input  logic [SB_N-1:0]           sb_reset_i,
  output logic [SB_N-1:0]           freeze_o,
  output logic [SB_N*PB_MODE_W-1:0] playback_mode_o,
  output logic                      init_spy_mem_o,
  output logic [SB_N-1:0]           sb_reset_o,
  output logic [1:0]                state_o,
  output logic [15:0]               trig_cnt_o
);

  localparam int unsigned RC_W = $clog2(RST_PULSE_CYCLES + 1);
  localparam logic [RC_W-1:0] RC_LOAD = RC_W'(RST_PULSE_CYCLES);

  if (SB_N < 1 || SB_N > 1024 || RST_PULSE_CYCLES < 1 || FROZEN_HOLD < 1) begin : g_param_check
    $error("fm_sb_ctrl_trig: parameter out of range");
  end

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_DELAY  = 2'd2,
    ST_FROZEN = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [DELAY_W-1:0]   dly_cnt_q, dly_cnt_d;
  logic [15:0]          trig_cnt_q, trig_cnt_d;
  logic                 arm_q, init_q;
  logic [SB_N-1:0]      sbr_q;
  logic [SB_N-1:0]      pend_q, pend_d;
  logic [RC_W-1:0]      rst_cnt_q, rst_cnt_d;
  logic [SB_N-1:0]      freeze_q;
  logic [SB_N*PB_MODE_W-1:0] pb_q;
  logic                 init_out_q;

  logic                 arm_rise, init_rise;
  logic [SB_N-1:0]      sbr_rise;

`ifdef FM_SB_CTRL_AUTO_REARM_EN
  localparam int unsigned HOLD_W = (FROZEN_HOLD > 1) ? $clog2(FROZEN_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(FROZEN_HOLD - 1);
  logic [HOLD_W-1:0]    hold_cnt_q, hold_cnt_d;
`endif

  assign arm_rise  = arm_i & ~arm_q;
  assign init_rise = init_spy_mem_i & ~init_q;
  assign sbr_rise  = sb_reset_i & ~sbr_q;

  // Trigger FSM next state: init beats everything, then arm-low abort, then normal flow
  always_comb begin
    state_d    = state_q;
    dly_cnt_d  = dly_cnt_q;
    trig_cnt_d = trig_cnt_q;
`ifdef FM_SB_CTRL_AUTO_REARM_EN
    hold_cnt_d = '0;
`endif
    if (init_rise) begin
      state_d    = ST_IDLE;
      dly_cnt_d  = '0;
      trig_cnt_d = '0;
    end else if (state_q != ST_IDLE && !arm_i) begin
      state_d   = ST_IDLE;
      dly_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (arm_rise) state_d = ST_ARMED;
        end
        ST_ARMED: begin
          if (trig_i) begin
            if (post_trig_dly_i == '0) begin
              state_d = ST_FROZEN;
            end else begin
              state_d   = ST_DELAY;
              dly_cnt_d = post_trig_dly_i;
            end
            if (trig_cnt_q != 16'hFFFF) trig_cnt_d = trig_cnt_q + 16'd1;
          end
        end
        ST_DELAY: begin
          if (dly_cnt_q == DELAY_W'(1)) begin
            state_d   = ST_FROZEN;
            dly_cnt_d = '0;
          end else begin
            dly_cnt_d = dly_cnt_q - DELAY_W'(1);
          end
        end
        ST_FROZEN: begin
`ifdef FM_SB_CTRL_AUTO_REARM_EN
          // arm_i is known high here; the low case already left via the abort branch
          if (hold_cnt_q == HOLD_LAST) begin
            state_d = ST_ARMED;
          end else begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
          end
`endif
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Reset stretch: new edges join the pending mask and restart the full pulse
  always_comb begin
    pend_d    = pend_q;
    rst_cnt_d = rst_cnt_q;
    if (|sbr_rise) begin
      pend_d    = pend_q | sbr_rise;
      rst_cnt_d = RC_LOAD;
    end else if (rst_cnt_q != '0) begin
      rst_cnt_d = rst_cnt_q - RC_W'(1);
      if (rst_cnt_q == RC_W'(1)) pend_d = '0;
    end
  end

  // State, counters and edge-detect history
  always_ff @(posedge axi_clk or posedge axi_reset) begin
    if (axi_reset) begin
      state_q    <= ST_IDLE;
      dly_cnt_q  <= '0;
      trig_cnt_q <= '0;
      arm_q      <= 1'b0;
      init_q     <= 1'b0;
      sbr_q      <= '0;
      pend_q     <= '0;
      rst_cnt_q  <= '0;
`ifdef FM_SB_CTRL_AUTO_REARM_EN
      hold_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      dly_cnt_q  <= dly_cnt_d;
      trig_cnt_q <= trig_cnt_d;
      arm_q      <= arm_i;
      init_q     <= init_spy_mem_i;
      sbr_q      <= sb_reset_i;
      pend_q     <= pend_d;
      rst_cnt_q  <= rst_cnt_d;
`ifdef FM_SB_CTRL_AUTO_REARM_EN
      hold_cnt_q <= hold_cnt_d;
`endif
    end
  end

  // Registered per-channel freeze, playback mode and init pulse
  always_ff @(posedge axi_clk or posedge axi_reset) begin
    if (axi_reset) begin
      freeze_q   <= '0;
      pb_q       <= '0;
      init_out_q <= 1'b0;
    end else begin
      freeze_q   <= {SB_N{global_freeze_i | (state_q == ST_FROZEN)}} & ~freeze_mask_i;
      init_out_q <= init_rise;
      for (int unsigned i = 0; i < SB_N; i++) begin
        pb_q[i*PB_MODE_W +: PB_MODE_W] <= playback_mask_i[i] ? '0 : pb_mode_i;
      end
    end
  end

  assign freeze_o        = freeze_q;
  assign playback_mode_o = pb_q;
  assign init_spy_mem_o  = init_out_q;
  assign sb_reset_o      = (rst_cnt_q != '0) ? pend_q : '0;
  assign state_o         = state_q;
  assign trig_cnt_o      = trig_cnt_q;

endmodule
